// File: rtl/styler_uart_tx.sv
// styler_uart_tx: small byte FIFO feeding an 8N1 serial transmitter.
// Bytes arrive over a valid/ready handshake and leave LSB first on tx.
//
// state | meaning
// IDLE  | line held high, waiting for a buffered byte
// START | start bit, line low
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high; chains straight into the next start bit if a byte waits
module styler_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          push, pop;

  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  // Byte storage; contents are only ever read behind a non-zero count, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Circular-buffer pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Frame sequencing; the baud timer counts down and each bit ends at terminal count zero.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          baud_nxt  = BAUD_LAST;
          state_nxt = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_nxt    = BAUD_LAST;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_nxt    = BAUD_LAST;
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            baud_nxt  = BAUD_LAST;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is registered, so it is computed from the state being entered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // State, timers and the registered serial line; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_styler_uart_tx.sv
// Bench for styler_uart_tx: two instances (4 and 2 clocks per bit) checked against a
// timeline model. The model records the edge each byte is accepted and derives its
// frame start as max(accept + 1, previous start + 10 bit times); FIFO occupancy, busy
// and the idle line level follow from those two event lists.
`timescale 1ns/1ps
module tb_styler_uart_tx;
  localparam int C0    = 4;
  localparam int C1    = 2;
  localparam int DEPTH = 4;
  localparam int FAR   = -100000;

  typedef struct {
    logic [7:0] d;
    int         s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = '0, d1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       r0, r1, tx0, tx1, b0, b1;
  logic [2:0] fc0, fc1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int   acc0[$], st0[$], acc1[$], st1[$];
  int   last0 = FAR, last1 = FAR;
  exp_t sb0[$], sb1[$];

  styler_uart_tx #(.CLKS_PER_BIT(C0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .tx(tx0), .busy(b0), .fifo_count(fc0));

  styler_uart_tx #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .tx(tx1), .busy(b1), .fifo_count(fc1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic int mcount(input int idx, input int t);
    int n = 0;
    if (idx == 0) begin
      foreach (acc0[i]) if (acc0[i] <= t) n++;
      foreach (st0[i])  if (st0[i] <= t)  n--;
    end else begin
      foreach (acc1[i]) if (acc1[i] <= t) n++;
      foreach (st1[i])  if (st1[i] <= t)  n--;
    end
    return n;
  endfunction

  function automatic bit mactive(input int idx, input int t);
    bit a = 1'b0;
    if (idx == 0) begin
      foreach (st0[i]) if (st0[i] <= t && t < st0[i] + 10 * C0) a = 1'b1;
    end else begin
      foreach (st1[i]) if (st1[i] <= t && t < st1[i] + 10 * C1) a = 1'b1;
    end
    return a;
  endfunction

  function automatic logic txl(input int idx);
    return (idx == 0) ? tx0 : tx1;
  endfunction

  task automatic accept(input int idx, input logic [7:0] b, input int a);
    exp_t e;
    int   s;
    e.d = b;
    if (idx == 0) begin
      s = (a + 1 > last0 + 10 * C0) ? a + 1 : last0 + 10 * C0;
      acc0.push_back(a); st0.push_back(s); last0 = s;
      e.s = s; sb0.push_back(e);
    end else begin
      s = (a + 1 > last1 + 10 * C1) ? a + 1 : last1 + 10 * C1;
      acc1.push_back(a); st1.push_back(s); last1 = s;
      e.s = s; sb1.push_back(e);
    end
  endtask

  // Called at a falling edge; presents b and holds it until the model says it is taken.
  task automatic send(input int idx, input logic [7:0] b, output int a);
    int waited = 0;
    a = -1;
    if (idx == 0) begin d0 = b; v0 = 1'b1; end
    else          begin d1 = b; v1 = 1'b1; end
    while (a < 0 && waited < 500) begin
      if (mcount(idx, cyc) != DEPTH) begin
        a = cyc + 1;
        accept(idx, b, a);
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    if (a < 0) chk($sformatf("send_timeout%0d", idx), 0, 1);
  endtask

  task automatic idle(input int n);
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Reset with a push presented on both inputs; the model forgets everything.
  task automatic do_reset(input int n);
    rst = 1'b1;
    v0 = 1'b1; d0 = 8'($urandom);
    v1 = 1'b1; d1 = 8'($urandom);
    acc0.delete(); st0.delete(); sb0.delete(); last0 = FAR;
    acc1.delete(); st1.delete(); sb1.delete(); last1 = FAR;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic check_dut(input int idx);
    int mc;
    bit act;
    mc  = mcount(idx, cyc);
    act = mactive(idx, cyc);
    if (idx == 0) begin
      chk("fifo_count0", int'(fc0), mc);
      chk("in_ready0", int'(r0), int'(mc != DEPTH));
      chk("busy0", int'(b0), int'(mc != 0 || act));
      if (!act) chk("tx_idle0", int'(tx0), 1);
    end else begin
      chk("fifo_count1", int'(fc1), mc);
      chk("in_ready1", int'(r1), int'(mc != DEPTH));
      chk("busy1", int'(b1), int'(mc != 0 || act));
      if (!act) chk("tx_idle1", int'(tx1), 1);
    end
  endtask

  // Frame monitor: on a falling line it pops the next expected byte and
  // compares the whole 10-bit waveform, the decoded byte and the start time.
  task automatic monitor(input int idx);
    int c;
    c = (idx == 0) ? C0 : C1;
    forever begin
      @(posedge clk); #1;
      if (chk_en && !rst && txl(idx) == 1'b0) begin
        exp_t       e;
        logic [9:0] frame;
        logic [7:0] dec;
        int         s;
        int         bad;
        bit         aborted;
        bit         have;
        s = cyc; bad = 0; aborted = 1'b0; have = 1'b0; dec = '0;
        e.d = '0; e.s = 0;
        if (idx == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        if (idx == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        chk($sformatf("frame_expected%0d", idx), int'(have), 1);
        frame = {1'b1, e.d, 1'b0};
        for (int i = 0; i < 10 * c; i++) begin
          logic lvl;
          if (i > 0) begin @(posedge clk); #1; end
          if (rst) begin aborted = 1'b1; break; end
          lvl = txl(idx);
          if (lvl != frame[i / c]) bad++;
          if (i % c == c / 2 && i / c >= 1 && i / c <= 8) dec[i / c - 1] = lvl;
        end
        if (have && !aborted) begin
          chk($sformatf("start_time%0d", idx), s, e.s);
          chk($sformatf("byte%0d", idx), int'(dec), int'(e.d));
          chk($sformatf("waveform_bad_samples%0d", idx), bad, 0);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Per-cycle occupancy / handshake / busy / idle-line checks.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (chk_en) begin
        check_dut(0);
        check_dut(1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a_first, a_last, t;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Single byte 0x55
    send(0, 8'h55, a);
    idle(60);

    // Fill and back-pressure: 0xA1..0xA6 on consecutive cycles
    a_first = 0;
    a_last  = 0;
    for (int i = 0; i < 6; i++) begin
      send(0, 8'(8'hA1 + i), a);
      if (i == 0) a_first = a;
      a_last = a;
    end
    chk("a6_accept_delay", a_last - a_first, 10 * C0 + 2);
    idle(6 * 10 * C0 + 20);

    // Wrap-around stream 0x00..0x13 with valid held high
    for (int i = 0; i < 20; i++) send(0, 8'(i), a);
    idle(6 * 10 * C0 + 20);

    // Random bytes with random gaps
    for (int i = 0; i < 15; i++) begin
      send(0, 8'($urandom), a);
      idle($urandom_range(0, 60));
    end
    idle(5 * 10 * C0 + 20);

    // Reset during data bit 3 of 0xF0 with 0x0F queued behind it
    send(0, 8'hF0, a);
    t = last0;
    send(0, 8'h0F, a);
    v0 = 1'b0;
    while (cyc < t + 4 * C0) @(negedge clk);
    do_reset(2);
    idle(100);

    // Minimum divider: 0x80 at two clocks per bit, then a random back-to-back burst
    send(1, 8'h80, a);
    idle(40);
    for (int i = 0; i < 8; i++) send(1, 8'($urandom), a);
    idle(10 * 10 * C1);

    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
